pixel_gather: RTL and testbench

PIXEL_GATHER -- requirements
Module: pixel_gather

---
 rtl/pixel_gather.sv | 149 ++++++++++++++
 tb/tb_pixel_gather.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_gather.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : pixel_gather                                               |
// | Brief    : Captures the five RAM samples of a point pair and reports  |
// |            their contrast and edge decision.                          |
// | Config   : RAM_OUTREG_EN selects a two-cycle RAM read latency.        |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
module pixel_gather #(
  parameter int DW  = 8,
  parameter int THR = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            cal_point_rdy,
  input  logic            w_en,
  input  logic [DW-1:0]   q_a,
  input  logic [DW-1:0]   q_b,
  output logic [5*DW-1:0] pix_a,
  output logic [5*DW-1:0] pix_b,
  output logic [DW+2:0]   contrast,
  output logic            is_edge,    // "edge" is a reserved word
  output logic            out_valid,
  output logic            busy
);

`ifdef RAM_OUTREG_EN
  localparam int C_LAT = 2;
`else
  localparam int C_LAT = 1;
`endif
  localparam int C_SW = DW + 3;
  localparam logic signed [C_SW-1:0] C_THR = C_SW'(THR);

  logic [2:0]       r_cnt;
  logic             w_rd;
  logic             w_adv;
  logic [C_LAT-1:0] r_d_rd;
  logic [2:0]       r_d_cnt [C_LAT];
  logic             w_cap;
  logic [2:0]       w_idx;
  logic             w_fire;
  logic [4:0]       r_flag;
  logic [DW-1:0]    r_slot_a [4];
  logic [DW-1:0]    r_slot_b [4];
  logic [C_SW-1:0]  w_sum_a;
  logic [C_SW-1:0]  w_sum_b;
  logic [C_SW-1:0]  w_diff;
  logic [5*DW-1:0]  r_pix_a;
  logic [5*DW-1:0]  r_pix_b;
  logic [C_SW-1:0]  r_contrast;
  logic             r_edge;
  logic             r_out_valid;

  assign w_rd  = start & cal_point_rdy & ~w_en;
  assign w_adv = start & cal_point_rdy & (r_cnt < 3'd4);

  // Mirror of the address generator's point counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= 3'd0;
    end else begin
      r_cnt <= w_adv ? r_cnt + 3'd1 : 3'd0;
    end
  end

  // Align the read qualifier and point index with the RAM read latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_d_rd <= '0;
      for (int i = 0; i < C_LAT; i++) begin
        r_d_cnt[i] <= 3'd0;
      end
    end else begin
      r_d_rd[0]  <= w_rd;
      r_d_cnt[0] <= r_cnt;
      for (int i = 1; i < C_LAT; i++) begin
        r_d_rd[i]  <= r_d_rd[i-1];
        r_d_cnt[i] <= r_d_cnt[i-1];
      end
    end
  end

  assign w_cap  = r_d_rd[C_LAT-1];
  assign w_idx  = r_d_cnt[C_LAT-1];
  assign w_fire = w_cap & (w_idx == 3'd4) & (&r_flag[3:0]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_flag <= 5'd0;
      for (int k = 0; k < 4; k++) begin
        r_slot_a[k] <= '0;
        r_slot_b[k] <= '0;
      end
    end else if (!w_cap) begin
      r_flag <= 5'd0;
    end else begin
      // Slot 0 opens a fresh sequence, discarding any stale partial one.
      if (w_idx == 3'd0) begin
        r_flag <= 5'b00001;
      end else if (w_idx <= 3'd4) begin
        r_flag[w_idx] <= 1'b1;
      end
      if (w_idx < 3'd4) begin
        r_slot_a[w_idx[1:0]] <= q_a;
        r_slot_b[w_idx[1:0]] <= q_b;
      end
    end
  end

  always_comb begin
    w_sum_a = '0;
    w_sum_b = '0;
    for (int k = 0; k < 4; k++) begin
      w_sum_a = w_sum_a + C_SW'(r_slot_a[k]);
      w_sum_b = w_sum_b + C_SW'(r_slot_b[k]);
    end
    w_diff = w_sum_b - w_sum_a;
  end

  // Slot 4 is taken straight from the RAM so the result lands one edge earlier.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pix_a     <= '0;
      r_pix_b     <= '0;
      r_contrast  <= '0;
      r_edge      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= w_fire;
      if (w_fire) begin
        r_pix_a    <= {q_a, r_slot_a[3], r_slot_a[2], r_slot_a[1], r_slot_a[0]};
        r_pix_b    <= {q_b, r_slot_b[3], r_slot_b[2], r_slot_b[1], r_slot_b[0]};
        r_contrast <= w_diff;
        r_edge     <= ($signed(w_diff) >= C_THR);
      end
    end
  end

  assign pix_a     = r_pix_a;
  assign pix_b     = r_pix_b;
  assign contrast  = r_contrast;
  assign is_edge   = r_edge;
  assign out_valid = r_out_valid;
  assign busy      = (|r_flag) | (|r_d_rd);

endmodule
`default_nettype wire

// File: tb/tb_pixel_gather.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : tb_pixel_gather                                            |
// | Brief    : Randomized scoreboard bench for pixel_gather.              |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
module tb_pixel_gather;
  localparam int DW  = 8;
  localparam int THR = 16;
`ifdef RAM_OUTREG_EN
  localparam int L = 2;
`else
  localparam int L = 1;
`endif
  localparam int NC = 3000;

  logic            clk;
  logic            rst;
  logic            start;
  logic            cal_point_rdy;
  logic            w_en;
  logic [DW-1:0]   q_a;
  logic [DW-1:0]   q_b;
  logic [5*DW-1:0] pix_a;
  logic [5*DW-1:0] pix_b;
  logic [DW+2:0]   contrast;
  logic            is_edge;
  logic            out_valid;
  logic            busy;

  pixel_gather #(.DW(DW), .THR(THR)) dut (
    .clk(clk), .rst(rst), .start(start), .cal_point_rdy(cal_point_rdy),
    .w_en(w_en), .q_a(q_a), .q_b(q_b), .pix_a(pix_a), .pix_b(pix_b),
    .contrast(contrast), .is_edge(is_edge), .out_valid(out_valid), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int              cyc;
    logic [5*DW-1:0] pa;
    logic [5*DW-1:0] pb;
    logic [DW+2:0]   con;
    logic            edg;
  } exp_t;

  exp_t sb[$];

  bit            st_h [NC];
  bit            cp_h [NC];
  bit            rs_h [NC];
  bit            rd_h [NC];
  int            cnt_h [NC];
  logic [DW-1:0] qa_h [NC];
  logic [DW-1:0] qb_h [NC];
  bit            dv [NC];
  logic [DW-1:0] da [NC];
  logic [DW-1:0] db [NC];

  int cyc   = -1;
  int total = 0;
  int bad   = 0;

  logic [5*DW-1:0] last_pa = '0;
  logic [5*DW-1:0] last_pb = '0;
  logic [DW+2:0]   last_con = '0;
  logic            last_edg = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit rs_ok(input int a, input int b);
    for (int j = a; j <= b; j++) begin
      if (j < 0 || !rs_h[j]) return 1'b0;
    end
    return 1'b1;
  endfunction

  // A result is due when five consecutive reads starting at point 0 went
  // out undisturbed by reset and the output cycle itself is not in reset.
  task automatic predict(input int s);
    bit   ok;
    exp_t e;
    int   sa;
    int   sbm;
    int   con;
    if (s < 0) return;
    ok = (cnt_h[s] == 0) && rs_ok(s, s + L + 5);
    for (int k = 0; k < 5; k++) ok = ok && rd_h[s+k];
    if (!ok) return;
    sa  = 0;
    sbm = 0;
    for (int k = 0; k < 5; k++) begin
      e.pa[k*DW +: DW] = qa_h[s+k+L];
      e.pb[k*DW +: DW] = qb_h[s+k+L];
      if (k < 4) begin
        sa  += int'(qa_h[s+k+L]);
        sbm += int'(qb_h[s+k+L]);
      end
    end
    con   = sbm - sa;
    e.cyc = s + L + 5;
    e.con = con[DW+2:0];
    e.edg = (con >= THR);
    sb.push_back(e);
  endtask

  task automatic step(input bit st, input bit cp, input bit we, input bit rs);
    @(posedge clk);
    #1;
    cyc++;
    st_h[cyc] = st;
    cp_h[cyc] = cp;
    rs_h[cyc] = rs;
    rd_h[cyc] = st && cp && !we;
    if (cyc == 0 || !rs || !rs_h[cyc-1]) cnt_h[cyc] = 0;
    else if (st_h[cyc-1] && cp_h[cyc-1] && cnt_h[cyc-1] < 4) cnt_h[cyc] = cnt_h[cyc-1] + 1;
    else cnt_h[cyc] = 0;
    qa_h[cyc] = dv[cyc] ? da[cyc] : DW'($urandom_range(0, (1 << DW) - 1));
    qb_h[cyc] = dv[cyc] ? db[cyc] : DW'($urandom_range(0, (1 << DW) - 1));
    start = st;
    cal_point_rdy = cp;
    w_en = we;
    rst = rs;
    q_a = qa_h[cyc];
    q_b = qb_h[cyc];
    predict(cyc - L - 5);
  endtask

  task automatic plan(input int s, input int a[5], input int b[5]);
    for (int k = 0; k < 5; k++) begin
      dv[s+L+k] = 1'b1;
      da[s+L+k] = DW'(a[k]);
      db[s+L+k] = DW'(b[k]);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Monitor: reset values, busy, scoreboard pops and output holding.
  always @(negedge clk) begin
    if (cyc >= 0) begin
      automatic int   c = cyc;
      automatic bit   bexp = 1'b0;
      automatic exp_t e;
      if (rs_h[c]) begin
        for (int j = c - 1 - L; j <= c - 1; j++) begin
          if (j >= 0 && rd_h[j] && rs_ok(j, c)) bexp = 1'b1;
        end
      end
      chk("busy", 64'(busy), 64'(bexp));
      while (sb.size() > 0 && sb[0].cyc < c) begin
        e = sb.pop_front();
        chk("missing out_valid", 64'(0), 64'(e.cyc));
      end
      if (!rs_h[c]) begin
        chk("reset outputs", 64'({out_valid, is_edge, |contrast, |pix_a, |pix_b}), 64'(0));
        last_pa = '0; last_pb = '0; last_con = '0; last_edg = 1'b0;
      end else if (out_valid) begin
        if (sb.size() == 0) begin
          chk("spurious out_valid", 64'(c), 64'(0));
        end else begin
          e = sb.pop_front();
          chk("valid cycle", 64'(c), 64'(e.cyc));
          chk("pix_a", 64'(pix_a), 64'(e.pa));
          chk("pix_b", 64'(pix_b), 64'(e.pb));
          chk("contrast", 64'(contrast), 64'(e.con));
          chk("edge", 64'(is_edge), 64'(e.edg));
          last_pa = e.pa; last_pb = e.pb; last_con = e.con; last_edg = e.edg;
        end
      end else begin
        chk("hold", 64'({pix_a == last_pa, pix_b == last_pb, contrast == last_con, is_edge == last_edg}),
            64'(4'hF));
      end
    end
  end

  initial begin
    int pa5[5];
    int pb5[5];
    int s;
    int n;
    rst = 1'b0; start = 1'b0; cal_point_rdy = 1'b0; w_en = 1'b0;
    q_a = '0; q_b = '0;
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);

    // Nominal contrast example.
    s = cyc + 1;
    pa5 = '{10, 20, 30, 40, 50};
    pb5 = '{15, 25, 35, 45, 50};
    plan(s, pa5, pb5);
    repeat (5) step(1'b1, 1'b1, 1'b0, 1'b1);
    idle(8);
    @(negedge clk);
    chk("nominal contrast", 64'(int'($signed(contrast))), 64'(20));
    chk("nominal edge", 64'(is_edge), 64'(1));
    chk("nominal slot4", 64'(pix_a[4*DW +: DW]), 64'(50));

    // Most negative contrast.
    s = cyc + 1;
    pa5 = '{255, 255, 255, 255, 7};
    pb5 = '{0, 0, 0, 0, 9};
    plan(s, pa5, pb5);
    repeat (5) step(1'b1, 1'b1, 1'b0, 1'b1);
    idle(8);
    @(negedge clk);
    chk("min contrast", 64'(int'($signed(contrast))), 64'(-1020));
    chk("min edge", 64'(is_edge), 64'(0));

    // Abort after three points.
    repeat (3) step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    idle(8);

    // Three back-to-back sequences.
    repeat (15) step(1'b1, 1'b1, 1'b0, 1'b1);
    idle(8);

    // Reset in cycle 3, then a clean sequence.
    repeat (3) step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
    repeat (5) step(1'b1, 1'b1, 1'b0, 1'b1);
    idle(8);

    // ROI load phase ending mid count.
    repeat (3) step(1'b1, 1'b1, 1'b1, 1'b1);
    repeat (7) step(1'b1, 1'b1, 1'b0, 1'b1);
    idle(6);

    while (cyc < NC - 80) begin
      n = $urandom_range(1, 16);
      case ($urandom_range(0, 5))
        0: idle($urandom_range(1, 6));
        1: repeat (n) step(1'b1, 1'b1, 1'b0, 1'b1);
        2: repeat (n) step(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 7) != 0),
                           1'($urandom_range(0, 7) == 0), 1'b1);
        3: repeat ($urandom_range(1, 2)) step(1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        4: repeat (n) step(1'b1, 1'b1, 1'($urandom_range(0, 7) == 0), 1'b1);
        default: begin
          repeat (n) step(1'b1, 1'b1, 1'b0, 1'b1);
          step(1'b0, 1'b1, 1'b0, 1'b1);
          repeat (n) step(1'b1, 1'b1, 1'b0, 1'b1);
        end
      endcase
    end
    idle(12);
    @(negedge clk);
    chk("pending expectations", 64'(sb.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
